// File: rtl/fifo_uart_drain.sv
// rtl/fifo_uart_drain.sv - FIFO read-side drain: pops words and serialises them into bytes for the UART transmitter
//
// Ports:
//   rd_clk      FIFO read clock; all state is registered on its rising edge
//   reset_n     asynchronous active-low reset
//   enable      permits new words to be fetched (a word in flight always completes)
//   fifo_empty  FIFO empty flag (rd_clk domain)
//   fifo_data   FIFO registered read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  one-cycle read strobe per word
//   tx_data     byte offered to the UART transmitter
//   tx_valid    tx_data holds a byte
//   tx_ready    transmitter accepts the byte this cycle
//   busy        block is not idle
//   words_sent  count of fully transmitted words (wraps)

module fifo_uart_drain #(
  parameter int DATA_LEN    = 16,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   rd_clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   fifo_empty,
  input  logic [DATA_LEN-1:0]    fifo_data,
  output logic                   fifo_rd_en,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] words_sent
);

  localparam int BYTES  = DATA_LEN / 8;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    CAPTURE,
    SEND
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DATA_LEN-1:0] sreg;
  logic [BIDX_W-1:0]   bidx;
  logic [7:0]          cur_byte;
  logic                xfer;
  logic                last_xfer;

  // Byte bidx of the word, counted from whichever end goes out first.
  always_comb begin
    cur_byte = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (MSB_FIRST ? (int'(bidx) == BYTES - 1 - i) : (int'(bidx) == i)) begin
        cur_byte = sreg[8*i +: 8];
      end
    end
  end

  assign xfer      = (state == SEND) && tx_ready;
  assign last_xfer = xfer && (bidx == LAST_IDX);

  // Outputs depend on state only (plus sreg/bidx for the data); tx_ready
  // only steers the next state, so tx_valid cannot drop without a transfer.
  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (enable && !fifo_empty) begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        // The read is committed once issued, so enable is not looked at here.
        fifo_rd_en = 1'b1;
        state_nxt  = CAPTURE;
      end
      CAPTURE: begin
        state_nxt = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = cur_byte;
        if (last_xfer) begin
          state_nxt = (enable && !fifo_empty) ? FETCH : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sreg       <= '0;
      bidx       <= '0;
      words_sent <= '0;
    end else begin
      state <= state_nxt;
      if (state == CAPTURE) begin
        sreg <= fifo_data;
        bidx <= '0;
      end else if (xfer && !last_xfer) begin
        bidx <= bidx + BIDX_W'(1);
      end
      if (last_xfer) begin
        words_sent <= words_sent + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// tb/tb_fifo_uart_drain.sv - randomized scoreboard bench for fifo_uart_drain (MSB-first/16-bit and LSB-first/2-bit counter)

module tb_fifo_uart_drain;

  logic        rd_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [15:0] fifo_data = 16'h0;
  logic        tx_ready = 1'b0;

  logic        rd_en_a, rd_en_b;
  logic [7:0]  tx_data_a, tx_data_b;
  logic        tx_valid_a, tx_valid_b;
  logic        busy_a, busy_b;
  logic [15:0] ws_a;
  logic [1:0]  ws_b;

  always #10 rd_clk = ~rd_clk;

  fifo_uart_drain #(.DATA_LEN(16), .MSB_FIRST(1'b1), .COUNT_WIDTH(16)) dut_msb (
    .rd_clk(rd_clk), .reset_n(reset_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd_en(rd_en_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready), .busy(busy_a), .words_sent(ws_a)
  );

  fifo_uart_drain #(.DATA_LEN(16), .MSB_FIRST(1'b0), .COUNT_WIDTH(2)) dut_lsb (
    .rd_clk(rd_clk), .reset_n(reset_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd_en(rd_en_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready), .busy(busy_b), .words_sent(ws_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] fifo_q[$];
  logic [7:0]  exp_a[$];
  logic [7:0]  exp_b[$];
  bit          pending_rd = 0;
  int          bytes_a = 0, bytes_b = 0;
  logic [15:0] exp_ws_a = '0;
  logic [1:0]  exp_ws_b = '0;
  bit          prev_stall_a = 0, prev_stall_b = 0;
  logic [7:0]  prev_data_a = '0, prev_data_b = '0;
  bit          prev_rd_a = 0, prev_rd_b = 0;
  int          cyc = 0;
  int          rd_count = 0;
  int          last_rd_cyc = -1;
  bit          chk_spacing = 0;
  int          xfers = 0;

  // Stimulus control
  int          mode = 0;          // 0 direct, 1 backpressure, 2 random
  bit          en_cmd = 0, rdy_cmd = 0, rst_cmd = 0;
  int          stall = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_model();
    exp_a.delete();
    exp_b.delete();
    pending_rd   = 0;
    bytes_a      = 0;
    bytes_b      = 0;
    exp_ws_a     = '0;
    exp_ws_b     = '0;
    prev_stall_a = 0;
    prev_stall_b = 0;
    prev_rd_a    = 0;
    prev_rd_b    = 0;
    last_rd_cyc  = -1;
  endtask

  task automatic monitor();
    check_eq("words_sent_a", 32'(ws_a), 32'(exp_ws_a));
    check_eq("words_sent_b", 32'(ws_b), 32'(exp_ws_b));
    if (prev_stall_a) begin
      check_eq("hold_valid_a", 32'(tx_valid_a), 32'd1);
      check_eq("hold_data_a", 32'(tx_data_a), 32'(prev_data_a));
    end
    if (prev_stall_b) begin
      check_eq("hold_valid_b", 32'(tx_valid_b), 32'd1);
      check_eq("hold_data_b", 32'(tx_data_b), 32'(prev_data_b));
    end
    if (tx_valid_a || rd_en_a) check_eq("busy_a", 32'(busy_a), 32'd1);
    if (tx_valid_b || rd_en_b) check_eq("busy_b", 32'(busy_b), 32'd1);
    if (rd_en_a) begin
      check_eq("rd_pulse_a", 32'(prev_rd_a), 32'd0);
      check_eq("rd_nonempty", 32'(fifo_q.size() != 0), 32'd1);
      if (chk_spacing && last_rd_cyc >= 0) check_eq("rd_spacing", 32'(cyc - last_rd_cyc), 32'd4);
      last_rd_cyc = cyc;
      rd_count++;
      pending_rd = 1;
    end
    if (rd_en_b) check_eq("rd_pulse_b", 32'(prev_rd_b), 32'd0);
    if (tx_valid_a && tx_ready) begin
      if (exp_a.size() == 0) check_eq("extra_byte_a", 32'(tx_data_a), 32'hFFFF_FFFF);
      else check_eq("byte_a", 32'(tx_data_a), 32'(exp_a.pop_front()));
      bytes_a++;
      xfers++;
      if (bytes_a % 2 == 0) exp_ws_a++;
    end
    if (tx_valid_b && tx_ready) begin
      if (exp_b.size() == 0) check_eq("extra_byte_b", 32'(tx_data_b), 32'hFFFF_FFFF);
      else check_eq("byte_b", 32'(tx_data_b), 32'(exp_b.pop_front()));
      bytes_b++;
      if (bytes_b % 2 == 0) exp_ws_b++;
    end
    prev_stall_a = tx_valid_a && !tx_ready;
    prev_stall_b = tx_valid_b && !tx_ready;
    prev_data_a  = tx_data_a;
    prev_data_b  = tx_data_b;
    prev_rd_a    = rd_en_a;
    prev_rd_b    = rd_en_b;
  endtask

  // One clock: update the FIFO model after the edge, drive inputs, then check at the falling edge.
  task automatic cycle();
    logic [15:0] w;
    @(posedge rd_clk);
    cyc++;
    #1;
    reset_n = rst_cmd;
    if (pending_rd) begin
      if (fifo_q.size() > 0) begin
        w = fifo_q.pop_front();
        fifo_data = w;
        exp_a.push_back(w[15:8]);
        exp_a.push_back(w[7:0]);
        exp_b.push_back(w[7:0]);
        exp_b.push_back(w[15:8]);
      end
      pending_rd = 0;
    end
    case (mode)
      1: begin
        enable = en_cmd;
        if (tx_valid_a && stall < 5) begin
          tx_ready = 1'b0;
          stall++;
        end else begin
          tx_ready = tx_valid_a;
          stall = 0;
        end
      end
      2: begin
        enable   = ($urandom_range(0, 3) != 0);
        tx_ready = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 99) < 30) fifo_q.push_back(16'($urandom));
      end
      default: begin
        enable   = en_cmd;
        tx_ready = rdy_cmd;
      end
    endcase
    fifo_empty = (fifo_q.size() == 0);
    @(negedge rd_clk);
    monitor();
  endtask

  task automatic drain(input int limit);
    bit done;
    done   = 0;
    mode   = 0;
    en_cmd = 1;
    rdy_cmd = 1;
    for (int i = 0; i < limit && !done; i++) begin
      cycle();
      if (fifo_q.size() == 0 && !pending_rd && !busy_a && exp_a.size() == 0) done = 1;
    end
    check_eq("drain_done", 32'(done), 32'd1);
  endtask

  initial begin
    int  base_rd;
    logic lg_rd[6];
    logic lg_v[6];

    // Reset state
    rst_cmd = 0;
    for (int i = 0; i < 3; i++) cycle();
    check_eq("reset_valid", 32'(tx_valid_a | tx_valid_b), 32'd0);
    check_eq("reset_rd_en", 32'(rd_en_a | rd_en_b), 32'd0);
    check_eq("reset_busy", 32'(busy_a | busy_b), 32'd0);
    check_eq("reset_data", 32'({tx_data_a, tx_data_b}), 32'd0);
    rst_cmd = 1;
    for (int i = 0; i < 3; i++) cycle();

    // Single word 0xA55A: latency and byte order on both instances
    en_cmd = 1;
    rdy_cmd = 1;
    fifo_q.push_back(16'hA55A);
    for (int k = 0; k < 6; k++) begin
      cycle();
      lg_rd[k] = rd_en_a;
      lg_v[k]  = tx_valid_a;
    end
    for (int k = 0; k < 6; k++) begin
      check_eq($sformatf("lat_rd_en[%0d]", k), 32'(lg_rd[k]), 32'(k == 1));
      check_eq($sformatf("lat_valid[%0d]", k), 32'(lg_v[k]), 32'(k == 3 || k == 4));
    end
    check_eq("single_ws", 32'(ws_a), 32'd1);

    // Backpressure on 0x1234
    xfers = 0;
    fifo_q.push_back(16'h1234);
    mode = 1;
    for (int i = 0; i < 25; i++) cycle();
    check_eq("bp_transfers", 32'(xfers), 32'd2);
    check_eq("bp_ws", 32'(ws_a), 32'd2);
    mode = 0;

    // Burst of 8 words back to back
    base_rd = rd_count;
    last_rd_cyc = -1;
    chk_spacing = 1;
    for (int i = 0; i < 8; i++) fifo_q.push_back(16'($urandom));
    drain(100);
    chk_spacing = 0;
    check_eq("burst_reads", 32'(rd_count - base_rd), 32'd8);
    check_eq("burst_ws_a", 32'(ws_a), 32'd10);
    check_eq("burst_ws_b", 32'(ws_b), 32'd2);
    check_eq("burst_idle", 32'(busy_a), 32'd0);

    // enable dropped the cycle after word 2's FETCH
    base_rd = rd_count;
    for (int i = 0; i < 4; i++) fifo_q.push_back(16'($urandom));
    en_cmd = 1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (rd_count - base_rd == 2) en_cmd = 0;
    end
    check_eq("drop_reads", 32'(rd_count - base_rd), 32'd2);
    check_eq("drop_busy", 32'(busy_a), 32'd0);
    check_eq("drop_ws_a", 32'(ws_a), 32'd12);
    check_eq("drop_ws_b", 32'(ws_b), 32'd0);
    drain(100);
    check_eq("drop_final_ws", 32'(ws_a), 32'd14);

    // Randomized traffic
    mode = 2;
    for (int i = 0; i < 1500; i++) cycle();
    drain(3000);
    check_eq("rand_empty_a", 32'(exp_a.size()), 32'd0);
    check_eq("rand_empty_b", 32'(exp_b.size()), 32'd0);

    // Asynchronous reset in the middle of SEND
    en_cmd = 1;
    rdy_cmd = 0;
    fifo_q.push_back(16'hBEEF);
    for (int i = 0; i < 10 && !tx_valid_a; i++) cycle();
    check_eq("pre_reset_valid", 32'(tx_valid_a), 32'd1);
    #3;
    rst_cmd = 0;
    reset_n = 1'b0;
    #1;
    check_eq("async_valid", 32'(tx_valid_a | tx_valid_b), 32'd0);
    check_eq("async_rd_en", 32'(rd_en_a | rd_en_b), 32'd0);
    check_eq("async_busy", 32'(busy_a | busy_b), 32'd0);
    check_eq("async_ws", 32'({ws_a, ws_b}), 32'd0);
    check_eq("async_data", 32'({tx_data_a, tx_data_b}), 32'd0);
    clear_model();
    cycle();
    rst_cmd = 1;
    rdy_cmd = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_eq("post_reset_idle", 32'(busy_a | busy_b | rd_en_a), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/fifo_uart_drain.md
# fifo_uart_drain

Read-side drain controller for the 16-bit clock-crossing FIFO. It sits in the 50 MHz read clock domain, pops words from the FIFO read port, serialises each word into bytes and hands them to the UART transmitter through a valid/ready handshake. It is the only reader of the FIFO, so it owns the FIFO's read enable and sequences every read.

## Interface
- DATA_LEN, 16, FIFO word width; must be a multiple of 8; BYTES = DATA_LEN/8.
- MSB_FIRST, 1, 1: the most significant byte is sent first; 0: the least significant byte is sent first.
- COUNT_WIDTH, 16, width of the sent-word counter.

- rd_clk  in  1  single clock for the block (FIFO read clock).
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  permits new words to be fetched.
- fifo_empty  in  1  FIFO empty flag, in the rd_clk domain.
- fifo_data  in  DATA_LEN  FIFO registered read data, valid the cycle after a read.
- fifo_rd_en  out  1  FIFO read strobe, asserted for exactly one cycle per word.
- tx_data  out  8  byte to the UART transmitter.
- tx_valid  out  1  tx_data holds a byte.
- tx_ready  in  1  the UART transmitter accepts the byte.
- busy  out  1  high in any state other than IDLE.
- words_sent  out  COUNT_WIDTH  count of fully transmitted words.

## Operation
- State machine: IDLE, FETCH, CAPTURE, SEND.
- IDLE:
  - If enable && !fifo_empty, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - fifo_rd_en = 1, as a Moore output of this state.
  - Always go to CAPTURE. The read is committed, and enable is ignored here.
- CAPTURE:
  - Load fifo_data into shift register sreg.
  - Clear byte index bidx to 0.
  - Go to SEND.
- SEND:
  - tx_valid = 1.
  - tx_data = byte bidx of sreg: counted from the MSB end when MSB_FIRST = 1, from the LSB end when MSB_FIRST = 0.
  - Transfer occurs on a rising edge where tx_valid && tx_ready.
  - On a transfer with bidx < BYTES-1: bidx increments and the state stays SEND.
  - On a transfer with bidx == BYTES-1, words_sent increments (wrapping modulo 2^COUNT_WIDTH), then:
    - if enable && !fifo_empty, go to FETCH;
    - otherwise go to IDLE.
- Handshake rules:
  - tx_data and tx_valid are held stable while tx_ready is low.
  - tx_valid never deasserts without a transfer, except on reset.
  - tx_valid is combinational on state only; there is no path from tx_ready to tx_valid.
- enable deasserted mid-word: the current word (FETCH/CAPTURE/SEND) completes all bytes, then the block goes to IDLE.
- fifo_empty:
  - Sampled only in IDLE and on the last-byte transfer.
  - It cannot rise unexpectedly during FETCH, because this block is the only reader.
- Reset (reset_n low, any time, asynchronous):
  - State goes to IDLE; sreg, bidx and words_sent go to 0.
  - All outputs go to 0: fifo_rd_en, tx_valid, tx_data, busy, words_sent.
  - A word already popped but not yet fully sent is discarded.
  - Release is synchronised by the top-level reset synchroniser; the block adds none.

## Timing
- All registers are updated on the rising edge of rd_clk; reset is asynchronous.
- Latency with DATA_LEN = 16, counted from the edge at which IDLE samples enable && !fifo_empty (edge 0):
  - fifo_rd_en high in cycle 1.
  - fifo_data captured at edge 2.
  - tx_valid high with the first byte from cycle 3.
- Throughput with tx_ready held high:
  - BYTES + 2 cycles per word (4 cycles for 16 bits).
  - Back-to-back words: FETCH immediately follows the last-byte transfer; there is no IDLE cycle.
- tx_ready low stalls SEND indefinitely, with no timeout.
- words_sent updates on the same edge as the final byte transfer.
- busy = (state != IDLE), combinational from state.

## Test plan
- Reset: assert reset_n = 0 mid-SEND with tx_valid = 1 -> in the same cycle (asynchronously) tx_valid = 0, fifo_rd_en = 0, busy = 0, words_sent = 0; after release with fifo_empty = 1 the block stays in IDLE.
- Single word, MSB_FIRST = 1, fifo_data = 0xA55A, tx_ready = 1:
  - fifo_rd_en pulses for exactly 1 cycle;
  - bytes 0xA5 then 0x5A on consecutive cycles from cycle 3;
  - words_sent = 1.
  - Repeat with MSB_FIRST = 0 -> 0x5A then 0xA5.
- Backpressure: word 0x1234, tx_ready low for 5 cycles on each byte -> tx_data holds 0x12 (then 0x34) stable with tx_valid = 1 throughout each stall; exactly 2 transfers occur.
- Burst: 8 words queued, enable = 1, tx_ready = 1 -> 16 bytes in order, one fifo_rd_en every 4 cycles, words_sent = 8, return to IDLE once fifo_empty = 1.
- enable dropped in the cycle after FETCH of word 2 of 4 queued -> word 2 is fully sent, no further fifo_rd_en, busy = 0, words_sent = 2.
- Counter wrap: COUNT_WIDTH = 2, send 5 words -> words_sent sequence 1, 2, 3, 0, 1.
